// File: rtl/xlsu_load_if.sv
// Request, data-bus and writeback signals of the load unit.
// The slave modport is the load unit; the master modport is its environment.
interface xlsu_load_if;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] addr_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [4:0]  rd_i;
   logic [63:0] adr_o;
   logic [7:0]  sel_o;
   logic        cyc_o;
   logic        stb_o;
   logic [63:0] dat_i;
   logic        ack_i;
   logic        err_i;
   logic [4:0]  rd_o;
   logic [63:0] rdat_o;
   logic        rsx8_o;
   logic        rsx16_o;
   logic        rsx32_o;
   logic        rsx64_o;
   logic        rzx8_o;
   logic        rzx16_o;
   logic        rzx32_o;
   logic        fault_o;
   logic [1:0]  fault_cause_o;

   modport slave (
      input  valid_i, addr_i, size_i, unsigned_i, rd_i, dat_i, ack_i, err_i,
      output ready_o, adr_o, sel_o, cyc_o, stb_o, rd_o, rdat_o,
             rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o,
             fault_o, fault_cause_o
   );

   modport master (
      output valid_i, addr_i, size_i, unsigned_i, rd_i, dat_i, ack_i, err_i,
      input  ready_o, adr_o, sel_o, cyc_o, stb_o, rd_o, rdat_o,
             rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o,
             fault_o, fault_cause_o
   );
endinterface

// File: rtl/xlsu_load.sv
// Load unit: one 64-bit bus read per request, right-aligns the addressed bytes and
// issues a single-cycle writeback strobe telling xrs how to extend the data.
module xlsu_load #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   xlsu_load_if.slave  lsu
);
   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] adr_q, adr_d;
   logic [7:0]  sel_q, sel_d;
   logic [2:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [4:0]  rd_req_q, rd_req_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic [63:0] rdat_q, rdat_d;
   // one-hot: rsx8, rsx16, rsx32, rsx64, rzx8, rzx16, rzx32 (bit 0 upward)
   logic [6:0]  wb_q, wb_d;
   logic        fault_q, fault_d;
   logic [1:0]  cause_q, cause_d;

   logic        misaligned;
   logic [7:0]  sel_base;
   logic [63:0] shifted;
   logic [63:0] size_mask;
   logic [8:0]  cnt_inc;

   always_comb begin
      misaligned = 1'b0;
      sel_base   = 8'h01;
      case (lsu.size_i)
         2'd0: begin misaligned = 1'b0;                  sel_base = 8'h01; end
         2'd1: begin misaligned = lsu.addr_i[0];         sel_base = 8'h03; end
         2'd2: begin misaligned = |lsu.addr_i[1:0];      sel_base = 8'h0F; end
         default: begin misaligned = |lsu.addr_i[2:0];   sel_base = 8'hFF; end
      endcase
   end

   always_comb begin
      shifted   = lsu.dat_i >> {off_q, 3'b000};
      size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (size_q)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      cnt_inc = {1'b0, cnt_q} + 9'd1;
   end

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      off_d    = off_q;
      size_d   = size_q;
      uns_d    = uns_q;
      rd_req_d = rd_req_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      rdat_d   = rdat_q;
      cause_d  = cause_q;
      wb_d     = 7'd0;
      fault_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lsu.valid_i) begin
               off_d    = lsu.addr_i[2:0];
               size_d   = lsu.size_i;
               uns_d    = lsu.unsigned_i;
               rd_req_d = lsu.rd_i;
               if (misaligned) begin
                  state_d = ST_DONE;
                  fault_d = 1'b1;
                  cause_d = 2'b01;
               end else begin
                  adr_d   = {lsu.addr_i[63:3], 3'b000};
                  sel_d   = sel_base << lsu.addr_i[2:0];
                  cnt_d   = 8'd0;
                  state_d = ST_BUS;
               end
            end
         end
         ST_BUS: begin
            if (lsu.err_i) begin
               state_d = ST_DONE;
               fault_d = 1'b1;
               cause_d = 2'b10;
            end else if (lsu.ack_i) begin
               state_d = ST_DONE;
               rdat_d  = shifted & size_mask;
               rd_d    = rd_req_q;
               // x0 is never written: the read still completes but no strobe fires
               if (rd_req_q != 5'd0) begin
                  if (size_q == 2'd3 || !uns_q) wb_d[{1'b0, size_q}] = 1'b1;
                  else                          wb_d[3'd4 + {1'b0, size_q}] = 1'b1;
               end
            end else if (cnt_inc >= 9'(TIMEOUT_CYCLES)) begin
               state_d = ST_DONE;
               fault_d = 1'b1;
               cause_d = 2'b11;
            end else begin
               cnt_d = cnt_inc[7:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         adr_q    <= 64'd0;
         sel_q    <= 8'd0;
         off_q    <= 3'd0;
         size_q   <= 2'd0;
         uns_q    <= 1'b0;
         rd_req_q <= 5'd0;
         cnt_q    <= 8'd0;
         rd_q     <= 5'd0;
         rdat_q   <= 64'd0;
         wb_q     <= 7'd0;
         fault_q  <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         off_q    <= off_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         rd_req_q <= rd_req_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         rdat_q   <= rdat_d;
         wb_q     <= wb_d;
         fault_q  <= fault_d;
         cause_q  <= cause_d;
      end
   end

   assign lsu.ready_o       = (state_q == ST_IDLE);
   assign lsu.cyc_o         = (state_q == ST_BUS);
   assign lsu.stb_o         = (state_q == ST_BUS);
   assign lsu.adr_o         = adr_q;
   assign lsu.sel_o         = sel_q;
   assign lsu.rd_o          = rd_q;
   assign lsu.rdat_o        = rdat_q;
   assign lsu.rsx8_o        = wb_q[0];
   assign lsu.rsx16_o       = wb_q[1];
   assign lsu.rsx32_o       = wb_q[2];
   assign lsu.rsx64_o       = wb_q[3];
   assign lsu.rzx8_o        = wb_q[4];
   assign lsu.rzx16_o       = wb_q[5];
   assign lsu.rzx32_o       = wb_q[6];
   assign lsu.fault_o       = fault_q;
   assign lsu.fault_cause_o = cause_q;
endmodule

// File: tb/tb_xlsu_load.sv
// Directed and random loads against a byte-level reference model, with a small
// register-file stand-in that applies the unit's writeback strobes.
module tb_xlsu_load;
   logic clk;
   logic rst;
   xlsu_load_if bus();

   xlsu_load #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .lsu     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [63:0] last_rdat = 64'd0;
   logic [4:0]  last_rd = 5'd0;

   // register file stand-in: extends rdat_o according to whichever strobe fires
   logic [63:0] xrs [32];
   logic        xrs_clear;
   always @(posedge clk) begin
      if (xrs_clear) begin
         for (int i = 0; i < 32; i++) xrs[i] <= 64'd0;
      end else if (bus.rd_o != 5'd0) begin
         if (bus.rsx8_o)  xrs[bus.rd_o] <= {{56{bus.rdat_o[7]}},  bus.rdat_o[7:0]};
         if (bus.rsx16_o) xrs[bus.rd_o] <= {{48{bus.rdat_o[15]}}, bus.rdat_o[15:0]};
         if (bus.rsx32_o) xrs[bus.rd_o] <= {{32{bus.rdat_o[31]}}, bus.rdat_o[31:0]};
         if (bus.rsx64_o) xrs[bus.rd_o] <= bus.rdat_o;
         if (bus.rzx8_o)  xrs[bus.rd_o] <= {56'd0, bus.rdat_o[7:0]};
         if (bus.rzx16_o) xrs[bus.rd_o] <= {48'd0, bus.rdat_o[15:0]};
         if (bus.rzx32_o) xrs[bus.rd_o] <= {32'd0, bus.rdat_o[31:0]};
      end
   end

   function automatic logic [6:0] strobes();
      return {bus.rzx32_o, bus.rzx16_o, bus.rzx8_o, bus.rsx64_o,
              bus.rsx32_o, bus.rsx16_o, bus.rsx8_o};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 ack after dly stb cycles, 1 err together with ack, 2 no response (timeout)
   task automatic do_load(input logic [63:0] a, input logic [1:0] sz, input logic u,
                          input logic [4:0] r, input int dly, input int mode,
                          input logic [63:0] d);
      int          nb, off, stb_cnt, exp_cnt;
      logic        mis;
      logic [63:0] exp_rdat, exp_ext;
      logic [6:0]  exp_wb;
      logic [7:0]  exp_sel;
      logic [1:0]  exp_cause;
      logic        ok;
      nb  = 1 << sz;
      off = int'(a % 8);
      mis = (a % 64'(nb)) != 64'd0;
      exp_rdat = 64'd0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) exp_rdat[8*i +: 8] = d[8*(off+i) +: 8];
      if (sz == 2'd3 || u) exp_ext = exp_rdat;
      else if (exp_rdat[8*nb-1]) exp_ext = exp_rdat | ~((64'd1 << (8*nb)) - 64'd1);
      else exp_ext = exp_rdat;
      exp_sel = 8'(((16'd1 << nb) - 16'd1) << off);
      ok = !mis && mode == 0;
      exp_wb = 7'd0;
      if (ok && r != 5'd0) exp_wb[(sz == 2'd3 || !u) ? int'(sz) : 4 + int'(sz)] = 1'b1;
      exp_cause = mis ? 2'b01 : (mode == 1) ? 2'b10 : 2'b11;
      exp_cnt   = mis ? 0 : (mode == 2) ? 4 : dly + 1;

      @(negedge clk);
      chk("ready_idle", 64'(bus.ready_o), 64'd1);
      bus.valid_i = 1'b1; bus.addr_i = a; bus.size_i = sz; bus.unsigned_i = u; bus.rd_i = r;
      @(negedge clk);
      bus.valid_i = 1'b0; bus.addr_i = {$urandom, $urandom}; bus.rd_i = 5'($urandom);
      bus.size_i = 2'($urandom); bus.unsigned_i = 1'($urandom);
      bus.dat_i = {$urandom, $urandom};
      stb_cnt = 0;
      while (bus.stb_o && stb_cnt < 20) begin
         chk("cyc", 64'(bus.cyc_o), 64'd1);
         chk("adr", bus.adr_o, {a[63:3], 3'b000});
         chk("sel", 64'(bus.sel_o), 64'(exp_sel));
         if (mode != 2 && stb_cnt == dly) begin
            bus.ack_i = 1'b1; bus.err_i = (mode == 1); bus.dat_i = d;
         end
         @(negedge clk);
         bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = {$urandom, $urandom};
         stb_cnt++;
      end
      chk("stb_cycles", 64'(stb_cnt), 64'(exp_cnt));
      chk("cyc_done", 64'(bus.cyc_o), 64'd0);
      chk("ready_done", 64'(bus.ready_o), 64'd0);
      chk("fault", 64'(bus.fault_o), 64'(!ok));
      if (!ok) chk("cause", 64'(bus.fault_cause_o), 64'(exp_cause));
      chk("strobes", 64'(strobes()), 64'(exp_wb));
      if (ok) begin last_rd = r; last_rdat = exp_rdat; end
      chk("rd_o", 64'(bus.rd_o), 64'(last_rd));
      chk("rdat_o", bus.rdat_o, last_rdat);
      @(negedge clk);
      chk("ready_after", 64'(bus.ready_o), 64'd1);
      chk("strobes_after", 64'(strobes() | 7'(bus.fault_o)), 64'd0);
      if (ok && r != 5'd0) chk("xrs_read", xrs[r], exp_ext);
      $display("load a=%h sz=%0d u=%0d rd=%0d mode=%0d mis=%0d rdat=%h", a, sz, u, r, mode, mis, bus.rdat_o);
   endtask

   localparam logic [63:0] D = 64'h1122334455667788;

   initial begin
      int m;
      bus.valid_i = 1'b0; bus.addr_i = 64'd0; bus.size_i = 2'd0; bus.unsigned_i = 1'b0;
      bus.rd_i = 5'd0; bus.dat_i = 64'd0; bus.ack_i = 1'b0; bus.err_i = 1'b0;
      rst = 1'b1; xrs_clear = 1'b1;
      repeat (3) @(negedge clk);
      xrs_clear = 1'b0;
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      chk("rst_cyc_stb", 64'({bus.cyc_o, bus.stb_o}), 64'd0);
      chk("rst_adr_sel", bus.adr_o | 64'(bus.sel_o), 64'd0);
      chk("rst_rd_rdat", bus.rdat_o | 64'(bus.rd_o), 64'd0);
      chk("rst_fault", 64'({bus.fault_o, bus.fault_cause_o, strobes()}), 64'd0);
      rst = 1'b0;

      do_load(64'h1000, 2'd0, 1'b0, 5'd1, 2, 0, D);
      chk("xrs1", xrs[1], 64'hFFFF_FFFF_FFFF_FF88);
      do_load(64'h1002, 2'd1, 1'b1, 5'd2, 1, 0, D);
      do_load(64'h1004, 2'd2, 1'b0, 5'd3, 0, 0, D);
      do_load(64'h1000, 2'd3, 1'b1, 5'd4, 3, 0, D);
      do_load(64'h1001, 2'd1, 1'b0, 5'd5, 0, 0, D);
      do_load(64'h1008, 2'd2, 1'b0, 5'd6, 1, 1, D);
      do_load(64'h1010, 2'd3, 1'b0, 5'd7, 0, 2, D);

      // reset while the bus cycle is outstanding
      @(negedge clk);
      bus.valid_i = 1'b1; bus.addr_i = 64'h2000; bus.size_i = 2'd2; bus.rd_i = 5'd9;
      @(negedge clk);
      bus.valid_i = 1'b0;
      chk("pre_rst_stb", 64'(bus.stb_o), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_cyc", 64'({bus.cyc_o, bus.stb_o}), 64'd0);
      chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
      chk("mid_rst_out", 64'({bus.fault_o, strobes()}), 64'd0);
      last_rd = 5'd0; last_rdat = 64'd0;
      do_load(64'h1004, 2'd2, 1'b1, 5'd10, 1, 0, D);

      do_load(64'h1000, 2'd0, 1'b0, 5'd0, 1, 0, D);
      chk("x0_zero", xrs[0], 64'd0);

      for (int n = 0; n < 40; n++) begin
         m = $urandom_range(0, 5);
         do_load({$urandom, $urandom}, 2'($urandom), 1'($urandom), 5'($urandom),
                 $urandom_range(0, 3), (m < 4) ? 0 : m - 3, {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
